if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 19 +
 rtl/if_skid_buffer.sv | 53 +++++
 rtl/if_stage.sv | 150 +++++++++++++++
 tb/tb_if_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// if_stage_pkg
//   Shared definitions for the instruction-fetch stage: word width, the
//   fetch-state encoding and the default bubble instruction.
package if_stage_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  // REQ: request on the bus, waiting for a grant.
  // WAIT: request accepted, waiting for the returned word.
  typedef enum logic {
    REQ  = 1'b0,
    WAIT = 1'b1
  } fetch_state_t;

  localparam word_t NOP_INSTR = 16'h0800;

endpackage

// File: rtl/if_skid_buffer.sv
// if_skid_buffer
//   One-entry holding register for a fetched word that arrives while the
//   IF/ID register is frozen.
//   Ports:
//     clk, rst        clock, synchronous active-high reset (valid flag only)
//     wr              capture wr_data/wr_pc and mark the entry valid
//     rd              entry consumed by the IF/ID register
//     clr             drop the entry (redirect)
//     wr_data, wr_pc  word and its PC to capture
//     valid           entry holds a word
//     data, pc        stored word and its PC
module if_skid_buffer
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic        rd,
  input  logic        clr,
  input  logic [15:0] wr_data,
  input  logic [15:0] wr_pc,
  output logic        valid,
  output logic [15:0] data,
  output logic [15:0] pc
);

  word_t data_p0;
  word_t pc_p0;
  logic  vld_p0;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vld_p0 <= 1'b0;
    end else if (wr) begin
      vld_p0 <= 1'b1;
    end else if (rd) begin
      vld_p0 <= 1'b0;
    end
  end

  // Payload carries no reset; the valid flag alone qualifies it.
  always_ff @(posedge clk) begin
    if (wr) begin
      data_p0 <= wr_data;
      pc_p0   <= wr_pc;
    end
  end

  assign valid = vld_p0;
  assign data  = data_p0;
  assign pc    = pc_p0;

endmodule

// File: rtl/if_stage.sv
// if_stage
//   Instruction-fetch stage with a single outstanding request to a shared
//   RAM, a one-entry skid buffer for words returned during a stall, and the
//   IF/ID pipeline register.
//   Ports:
//     CLK, RST                    clock, synchronous active-high reset
//     freeze                      hazard stall, holds the IF/ID register
//     flush                       taken branch/jump, next IF/ID load is a bubble
//     redirectValid, redirectPC   new fetch target
//     memReq, memAddr             fetch request and address
//     memGnt                      request accepted this cycle
//     memRdy, memData             returned word
//     PCOut, instrOut, validOut   IF/ID register contents
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = if_stage_pkg::NOP_INSTR
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        freeze,
  input  logic        flush,
  input  logic        redirectValid,
  input  logic [15:0] redirectPC,
  output logic        memReq,
  output logic [15:0] memAddr,
  input  logic        memGnt,
  input  logic        memRdy,
  input  logic [15:0] memData,
  output logic [15:0] PCOut,
  output logic [15:0] instrOut,
  output logic        validOut
);

  fetch_state_t state;
  fetch_state_t state_next;

  word_t pc;
  word_t fetch_pc;
  word_t ret_pc;
  logic  discard;

  logic  buf_valid;
  word_t buf_data;
  word_t buf_pc;

  logic  accept;
  logic  rdy_wait;
  logic  live_rdy;
  logic  buf_wr;
  logic  buf_rd;

  always_comb begin
    memReq   = (state == REQ) && !buf_valid && !RST;
    memAddr  = pc;
    // A redirect in the same cycle overrides the grant.
    accept   = memReq && memGnt && !redirectValid;
    rdy_wait = (state == WAIT) && memRdy;
    // A return coinciding with a redirect is already stale.
    live_rdy = rdy_wait && !discard && !redirectValid;
    buf_wr   = freeze && live_rdy;
    buf_rd   = !freeze && !flush && buf_valid;
    // Returned words are tagged with the address after the fetched one.
    ret_pc   = fetch_pc + 16'd1;
  end

  always_comb begin
    state_next = state;
    case (state)
      REQ:     if (accept) state_next = WAIT;
      WAIT:    if (memRdy) state_next = REQ;
      default: state_next = REQ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= REQ;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc <= RESET_PC;
    end else if (redirectValid) begin
      pc <= redirectPC;
    end else if (accept) begin
      pc <= pc + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      fetch_pc <= pc;
    end
  end

  // discard marks the in-flight return as belonging to the old path.
  always_ff @(posedge CLK) begin
    if (RST) begin
      discard <= 1'b0;
    end else if (rdy_wait) begin
      discard <= 1'b0;
    end else if (redirectValid && (state == WAIT)) begin
      discard <= 1'b1;
    end
  end

  if_skid_buffer u_skid (
    .clk     (CLK),
    .rst     (RST),
    .wr      (buf_wr),
    .rd      (buf_rd),
    .clr     (redirectValid),
    .wr_data (memData),
    .wr_pc   (ret_pc),
    .valid   (buf_valid),
    .data    (buf_data),
    .pc      (buf_pc)
  );

  // ---- IF/ID register boundary ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      PCOut    <= 16'h0000;
      instrOut <= NOP_INSTR;
      validOut <= 1'b0;
    end else if (!freeze) begin
      if (flush) begin
        instrOut <= NOP_INSTR;
        validOut <= 1'b0;
      end else if (buf_valid) begin
        PCOut    <= buf_pc;
        instrOut <= buf_data;
        validOut <= 1'b1;
      end else if (live_rdy) begin
        PCOut    <= ret_pc;
        instrOut <= memData;
        validOut <= 1'b1;
      end else begin
        instrOut <= NOP_INSTR;
        validOut <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        freeze;
  logic        flush;
  logic        redirectValid;
  logic [15:0] redirectPC;
  logic        memReq;
  logic [15:0] memAddr;
  logic        memGnt;
  logic        memRdy;
  logic [15:0] memData;
  logic [15:0] PCOut;
  logic [15:0] instrOut;
  logic        validOut;

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] NOP = 16'h0800;

  if_stage #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0800)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .freeze        (freeze),
    .flush         (flush),
    .redirectValid (redirectValid),
    .redirectPC    (redirectPC),
    .memReq        (memReq),
    .memAddr       (memAddr),
    .memGnt        (memGnt),
    .memRdy        (memRdy),
    .memData       (memData),
    .PCOut         (PCOut),
    .instrOut      (instrOut),
    .validOut      (validOut)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Contents of the bench RAM: a fixed scramble of the address.
  function automatic logic [15:0] ram_word(input logic [15:0] a);
    logic [15:0] p;
    p = a * 16'h9E37;
    return p ^ 16'h5A5A;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  logic [15:0] exp_fetch;
  logic [15:0] exp_next;
  logic [15:0] ret_addr;
  logic [15:0] prev_pc;
  logic [15:0] prev_instr;
  logic        prev_valid;
  logic        was_freeze;
  logic        was_flush;
  bit          pending;
  int          cd;
  int          n_valid;

  initial begin
    RST = 1'b1; freeze = 1'b0; flush = 1'b0; redirectValid = 1'b0;
    redirectPC = 16'h0000; memGnt = 1'b0; memRdy = 1'b0; memData = 16'h0000;
    tick; tick;
    check("rst_pcout",   PCOut,              16'h0000);
    check("rst_instr",   instrOut,           NOP);
    check("rst_valid",   {15'b0, validOut},  16'h0000);
    check("rst_memreq",  {15'b0, memReq},    16'h0000);
    check("rst_memaddr", memAddr,            16'h0000);

    // First fetch: grant immediately, data one cycle later.
    RST = 1'b0; #1;
    check("first_req",  {15'b0, memReq}, 16'h0001);
    check("first_addr", memAddr,         16'h0000);
    memGnt = 1'b1; tick;
    check("wait_noreq", {15'b0, memReq}, 16'h0000);
    memGnt = 1'b0; memRdy = 1'b1; memData = 16'h6801; tick;
    check("t1_pc",    PCOut,             16'h0001);
    check("t1_instr", instrOut,          16'h6801);
    check("t1_valid", {15'b0, validOut}, 16'h0001);
    memRdy = 1'b0; memData = 16'h0000;

    // Bus busy for three cycles.
    for (int i = 0; i < 3; i++) begin
      check("busy_req",  {15'b0, memReq}, 16'h0001);
      check("busy_addr", memAddr,         16'h0001);
      tick;
      check("busy_valid", {15'b0, validOut}, 16'h0000);
      check("busy_instr", instrOut,          NOP);
    end

    // Return during a stall lands in the buffer.
    memGnt = 1'b1; tick;
    memGnt = 1'b0; freeze = 1'b1; memRdy = 1'b1; memData = 16'h4F05; tick;
    check("frz_pc",    PCOut,                     16'h0001);
    check("frz_instr", instrOut,                  NOP);
    check("frz_valid", {15'b0, validOut},         16'h0000);
    check("frz_buf",   {15'b0, dut.buf_valid},    16'h0001);
    check("frz_noreq", {15'b0, memReq},           16'h0000);
    memRdy = 1'b0; memData = 16'h0000; tick;
    check("frz2_noreq", {15'b0, memReq},   16'h0000);
    check("frz2_valid", {15'b0, validOut}, 16'h0000);
    freeze = 1'b0; tick;
    check("buf_pc",    PCOut,                  16'h0002);
    check("buf_instr", instrOut,               16'h4F05);
    check("buf_vout",  {15'b0, validOut},      16'h0001);
    check("buf_clear", {15'b0, dut.buf_valid}, 16'h0000);
    check("buf_req",   {15'b0, memReq},        16'h0001);
    check("buf_addr",  memAddr,                16'h0002);

    // Redirect with flush while a fetch is in flight.
    memGnt = 1'b1; tick;
    memGnt = 1'b0; redirectValid = 1'b1; redirectPC = 16'h0040; flush = 1'b1; tick;
    check("rd_valid", {15'b0, validOut}, 16'h0000);
    check("rd_instr", instrOut,          NOP);
    check("rd_pc",    PCOut,             16'h0002);
    check("rd_noreq", {15'b0, memReq},   16'h0000);
    redirectValid = 1'b0; flush = 1'b0; memRdy = 1'b1; memData = 16'hDEAD; tick;
    check("drop_valid", {15'b0, validOut}, 16'h0000);
    check("drop_instr", instrOut,          NOP);
    check("drop_req",   {15'b0, memReq},   16'h0001);
    check("drop_addr",  memAddr,           16'h0040);
    memRdy = 1'b0; memGnt = 1'b1; tick;
    memGnt = 1'b0; memRdy = 1'b1; memData = 16'h1234; tick;
    check("rd2_pc",    PCOut,             16'h0041);
    check("rd2_instr", instrOut,          16'h1234);
    check("rd2_valid", {15'b0, validOut}, 16'h0001);
    memRdy = 1'b0;

    // PC wrap from FFFF.
    redirectValid = 1'b1; redirectPC = 16'hFFFF; tick;
    redirectValid = 1'b0;
    check("wrap_addr_ffff", memAddr, 16'hFFFF);
    memGnt = 1'b1; tick;
    memGnt = 1'b0;
    check("wrap_next_addr", memAddr,         16'h0000);
    check("wrap_noreq",     {15'b0, memReq}, 16'h0000);
    memRdy = 1'b1; memData = 16'h5555; tick;
    memRdy = 1'b0;
    check("wrap_pc",    PCOut,             16'h0000);
    check("wrap_instr", instrOut,          16'h5555);
    check("wrap_valid", {15'b0, validOut}, 16'h0001);
    check("wrap_addr",  memAddr,           16'h0000);

    // Reset during WAIT, then a late return.
    memGnt = 1'b1; tick;
    memGnt = 1'b0;
    check("pre_rst_addr", memAddr, 16'h0001);
    RST = 1'b1; tick;
    check("rst2_pc",    PCOut,             16'h0000);
    check("rst2_instr", instrOut,          NOP);
    check("rst2_valid", {15'b0, validOut}, 16'h0000);
    check("rst2_req",   {15'b0, memReq},   16'h0000);
    check("rst2_addr",  memAddr,           16'h0000);
    RST = 1'b0; memRdy = 1'b1; memData = 16'hBEEF; tick;
    memRdy = 1'b0; memData = 16'h0000;
    check("late_pc",    PCOut,                  16'h0000);
    check("late_instr", instrOut,               NOP);
    check("late_valid", {15'b0, validOut},      16'h0000);
    check("late_req",   {15'b0, memReq},        16'h0001);
    check("late_addr",  memAddr,                16'h0000);
    check("late_buf",   {15'b0, dut.buf_valid}, 16'h0000);

    // Random traffic against a program-order scoreboard: fetch addresses
    // run sequentially from the last redirect target, every valid IF/ID
    // word is RAM[PCOut-1], and valid PCs follow each other by +1.
    exp_fetch = 16'h0000;
    exp_next  = 16'h0001;
    pending   = 1'b0;
    cd        = 0;
    ret_addr  = 16'h0000;
    n_valid   = 0;
    for (int c = 0; c < 3000; c++) begin
      memRdy  = 1'b0;
      memData = 16'h0000;
      if (pending) begin
        if (cd == 0) begin
          memRdy  = 1'b1;
          memData = ram_word(ret_addr);
          pending = 1'b0;
        end else begin
          cd--;
        end
      end
      freeze        = ($urandom_range(0, 3) == 0);
      redirectValid = 1'b0;
      flush         = 1'b0;
      if (!memRdy && ($urandom_range(0, 24) == 0)) begin
        redirectValid = 1'b1;
        flush         = 1'b1;
        redirectPC    = 16'($urandom);
        exp_fetch     = redirectPC;
        exp_next      = redirectPC + 16'd1;
      end
      memGnt = ($urandom_range(0, 2) != 0);
      if (memReq && memGnt && !redirectValid) begin
        check("rnd_addr",   memAddr,          exp_fetch);
        check("rnd_single", {15'b0, pending}, 16'h0000);
        ret_addr  = exp_fetch;
        exp_fetch = exp_fetch + 16'd1;
        pending   = 1'b1;
        cd        = int'($urandom_range(0, 3));
      end
      prev_pc    = PCOut;
      prev_instr = instrOut;
      prev_valid = validOut;
      was_freeze = freeze;
      was_flush  = flush;
      tick;
      if (was_freeze) begin
        check("rnd_hold_pc",    PCOut,             prev_pc);
        check("rnd_hold_instr", instrOut,          prev_instr);
        check("rnd_hold_valid", {15'b0, validOut}, {15'b0, prev_valid});
      end else if (was_flush) begin
        check("rnd_flush_valid", {15'b0, validOut}, 16'h0000);
        check("rnd_flush_instr", instrOut,          NOP);
        check("rnd_flush_pc",    PCOut,             prev_pc);
      end else if (validOut) begin
        check("rnd_pc",    PCOut,    exp_next);
        check("rnd_instr", instrOut, ram_word(PCOut - 16'd1));
        exp_next = PCOut + 16'd1;
        n_valid++;
      end else begin
        check("rnd_bubble", instrOut, NOP);
      end
    end
    check("rnd_progress", {15'b0, (n_valid > 100)}, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
